// File: rtl/filter_pkg.sv
// Shared types and constants for the recursive-filter stimulus path.
// The filter itself imports the same sample width and unit amplitude.
package filter_pkg;

   localparam int DATA_W    = 10;
   localparam int AMPLITUDE = 512;

   typedef enum logic [1:0] {
      MODE_LEVEL   = 2'b00,
      MODE_IMPULSE = 2'b01,
      MODE_SQUARE  = 2'b10,
      MODE_ZERO    = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      FIRED = 2'b10
   } imp_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// sw_d follows the synchronised input only after DB_CYCLES consecutive
// clocks of disagreement; sw_rise pulses for the first cycle sw_d is high.
module switch_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic sw_d,
   output logic sw_rise
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [1:0]       sync_r;
   logic             sw_s;
   logic             sw_d_r;
   logic             rise_r;
   logic [CNT_W-1:0] cnt_r;

   assign sw_s    = sync_r[1];
   assign sw_d    = sw_d_r;
   assign sw_rise = rise_r;

   // Synchronise the raw switch and accept a new level once it has held long enough.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= 2'b00;
         sw_d_r <= 1'b0;
         rise_r <= 1'b0;
         cnt_r  <= {CNT_W{1'b0}};
      end else begin
         sync_r <= {sync_r[0], sw_raw};
         rise_r <= 1'b0;
         if (sw_s == sw_d_r) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_r == CNT_W'(DB_CYCLES - 1)) begin
            sw_d_r <= sw_s;
            rise_r <= sw_s;
            cnt_r  <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/filter_sample_source.sv
// Stimulus source for y[n] = 0.5*y[n-1] + x[n]: debounced switch, sample
// strobe and waveform generator (level / impulse / square / zero).
// x_val, sample_idx and sample_tick are registered together, so x_val
// changes exactly in the cycle sample_tick is high.
// Optional build macro SAMPLE_SINGLE_STEP_EN replaces the free-running
// divider with one tick per debounced rising edge of step_req.
module filter_sample_source #(
   parameter int CLK_HZ    = 50000000,
   parameter int SAMPLE_HZ = 4,
   parameter int DATA_W    = filter_pkg::DATA_W,
   parameter int AMPLITUDE = filter_pkg::AMPLITUDE,
   parameter int DB_CYCLES = 500000,
   parameter int SQ_HALF   = 8
) (
   input  logic              MAX10_CLK1_50,
   input  logic              reset,
   input  logic              sw_x,
`ifdef SAMPLE_SINGLE_STEP_EN
   input  logic              step_req,
`endif
   input  logic [1:0]        mode,
   output logic              sample_tick,
   output logic [DATA_W-1:0] x_val,
   output logic [7:0]        sample_idx
);

   import filter_pkg::*;

   localparam int SQ_W = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;

   logic              sw_d_s;
   logic              sw_rise_s;
   logic              tick_s;
   mode_e             mode_s;
   imp_state_e        state_r;
   imp_state_e        state_n_s;
   logic              imp_x_s;
   logic              phase_r;
   logic              phase_n_s;
   logic [SQ_W-1:0]   sq_cnt_r;
   logic [SQ_W-1:0]   sq_cnt_n_s;
   logic              x_hi_s;
   logic              tick_r;
   logic [DATA_W-1:0] x_val_r;
   logic [7:0]        idx_r;

   assign mode_s      = mode_e'(mode);
   assign sample_tick = tick_r;
   assign x_val       = x_val_r;
   assign sample_idx  = idx_r;

   switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw_db (
      .clk     (MAX10_CLK1_50),
      .reset   (reset),
      .sw_raw  (sw_x),
      .sw_d    (sw_d_s),
      .sw_rise (sw_rise_s)
   );

`ifdef SAMPLE_SINGLE_STEP_EN
   logic step_d_s;

   switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
      .clk     (MAX10_CLK1_50),
      .reset   (reset),
      .sw_raw  (step_req),
      .sw_d    (step_d_s),
      .sw_rise (tick_s)
   );
`else
   localparam int DIV   = CLK_HZ / SAMPLE_HZ;
   localparam int DIV_W = $clog2(DIV);

   logic [DIV_W-1:0] div_cnt_r;

   assign tick_s = (div_cnt_r == DIV_W'(DIV - 1));

   // Free-running divider: counts 0..DIV-1 and wraps on the tick cycle.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end
`endif

   // Impulse FSM: arm on a switch rise, fire on the following tick, rearm after release.
   always_comb begin
      state_n_s = state_r;
      imp_x_s   = 1'b0;
      if (tick_s && (mode_s != MODE_IMPULSE)) begin
         state_n_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (sw_rise_s) state_n_s = ARMED;
               else           state_n_s = IDLE;
            end
            ARMED: begin
               if (tick_s) begin
                  state_n_s = FIRED;
                  imp_x_s   = 1'b1;
               end else begin
                  state_n_s = ARMED;
               end
            end
            FIRED: begin
               if (!sw_d_s) state_n_s = IDLE;
               else         state_n_s = FIRED;
            end
            default: state_n_s = IDLE;
         endcase
      end
   end

   // Square generator: phase flips at the start of every SQ_HALF-tick block.
   always_comb begin
      phase_n_s  = phase_r;
      sq_cnt_n_s = sq_cnt_r;
      if (!sw_d_s) begin
         phase_n_s  = 1'b0;
         sq_cnt_n_s = {SQ_W{1'b0}};
      end else if (tick_s) begin
         if (mode_s == MODE_SQUARE) begin
            if (sq_cnt_r == {SQ_W{1'b0}}) phase_n_s = ~phase_r;
            else                          phase_n_s = phase_r;
            if (sq_cnt_r == SQ_W'(SQ_HALF - 1)) sq_cnt_n_s = {SQ_W{1'b0}};
            else                                sq_cnt_n_s = sq_cnt_r + {{(SQ_W-1){1'b0}}, 1'b1};
         end else begin
            phase_n_s  = 1'b0;
            sq_cnt_n_s = {SQ_W{1'b0}};
         end
      end else begin
         phase_n_s  = phase_r;
         sq_cnt_n_s = sq_cnt_r;
      end
   end

   // Select whether the next sample is full scale or zero.
   always_comb begin
      x_hi_s = 1'b0;
      case (mode_s)
         MODE_LEVEL:   x_hi_s = sw_d_s;
         MODE_IMPULSE: x_hi_s = imp_x_s;
         MODE_SQUARE:  x_hi_s = sw_d_s & phase_n_s;
         MODE_ZERO:    x_hi_s = 1'b0;
         default:      x_hi_s = 1'b0;
      endcase
   end

   // Output and waveform state registers; sample path only updates on ticks.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
         tick_r   <= 1'b0;
         x_val_r  <= {DATA_W{1'b0}};
         idx_r    <= 8'd0;
         state_r  <= IDLE;
         phase_r  <= 1'b0;
         sq_cnt_r <= {SQ_W{1'b0}};
      end else begin
         tick_r   <= tick_s;
         state_r  <= state_n_s;
         phase_r  <= phase_n_s;
         sq_cnt_r <= sq_cnt_n_s;
         if (tick_s) begin
            x_val_r <= x_hi_s ? DATA_W'(AMPLITUDE) : {DATA_W{1'b0}};
            idx_r   <= idx_r + 8'd1;
         end
      end
   end

endmodule

// File: doc/filter_sample_source.md
Name: filter_sample_source

Overview:
- Upstream stimulus stage for the recursive filter y[n] = 0.5*y[n-1] + x[n].
- Debounces the raw input switch and generates a one-cycle sample strobe from the system clock.
- Produces the scaled input sample x[n] in a selectable waveform mode: level, impulse, square or zero.
- The filter consumes `sample_tick` as a clock enable. No derived clock is used anywhere.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- SAMPLE_HZ, 4: sample strobe rate in Hz. DIV = CLK_HZ/SAMPLE_HZ, and DIV must be ≥ 2.
- DATA_W, 10: width of the x sample, matching the filter and LED width.
- AMPLITUDE, 512: value representing 1.0. Must be < 2^DATA_W.
- DB_CYCLES, 500000: consecutive stable clocks needed to accept a switch change (10 ms).
- SQ_HALF, 8: square-wave half period, in samples.

Ports:
- MAX10_CLK1_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sw_x  in  1  raw, asynchronous input switch.
- mode  in  2  waveform select: 00 level, 01 impulse, 10 square, 11 zero.
- sample_tick  out  1  one-cycle strobe that marks a new x sample.
- x_val  out  DATA_W  current sample; changes only in the cycle sample_tick is high.
- sample_idx  out  8  count of ticks since reset, wrapping 255→0.

Behaviour:
- Reset values:
  - sample_tick = 0, x_val = 0, sample_idx = 0.
  - Divider count = 0, debounced state = 0, synchroniser flops = 0.
  - Impulse FSM = IDLE, square phase = 0, square count = 0.
- Synchroniser: sw_x passes through 2 flops, giving sw_s.
- Debouncer:
  - The counter resets whenever sw_s equals the debounced state sw_d.
  - Otherwise it increments. When it reaches DB_CYCLES-1, sw_d takes the value of sw_s and the counter clears.
  - Latency from a stable sw_x edge to the sw_d change is DB_CYCLES+2 clocks.
  - Glitches shorter than DB_CYCLES never reach sw_d.
- Divider:
  - Counts 0..DIV-1. sample_tick = 1 exactly when count == DIV-1, then the count wraps to 0.
  - Period is DIV clocks. The first tick arrives DIV clocks after reset is released.
- Update rule: x_val and sample_idx register on the tick cycle. x_val is stable for the whole interval between ticks.
- mode is sampled only on tick cycles, so a mode change takes effect at the next tick.
- Level mode (00): x_val = sw_d ? AMPLITUDE : 0.
- Impulse mode (01), FSM:
  - IDLE: moves to ARMED when sw_d rises.
  - ARMED: on the next tick, x_val = AMPLITUDE and the FSM moves to FIRED.
  - FIRED: x_val = 0 on every tick. Returns to IDLE when sw_d = 0.
  - In IDLE and ARMED, x_val = 0 on ticks.
  - A rise and a tick in the same cycle go to ARMED only. The pulse comes on the following tick.
  - If mode ≠ 01 on a tick, the FSM is forced to IDLE.
- Square mode (10):
  - While sw_d = 1, the phase toggles every SQ_HALF ticks and x_val = phase ? AMPLITUDE : 0.
  - The phase starts at 1 on the first tick after sw_d rises.
  - If sw_d = 0, phase and count clear and x_val = 0.
- Zero mode (11): x_val = 0.
- Width: x_val is always either 0 or AMPLITUDE. Nothing is computed arithmetically on the sample path.
- Reset mid-operation: every register returns to its reset value on the next clock edge. No tick is issued during that cycle.

Optional Feature:
- Macro: SAMPLE_SINGLE_STEP_EN.
- Defined:
  - Adds input `step_req` (1 bit, raw switch or key), which uses its own 2-flop synchroniser and DB_CYCLES debouncer.
  - The free-running divider is removed.
  - sample_tick fires for exactly one cycle on each debounced rising edge of step_req, allowing manual stepping of the filter.
- Undefined: no step_req port exists, and ticks come only from the divider.

Decomposition:
- Package `filter_pkg` holds:
  - the mode enum: MODE_LEVEL, MODE_IMPULSE, MODE_SQUARE, MODE_ZERO;
  - the impulse FSM state enum: IDLE, ARMED, FIRED;
  - constants DATA_W = 10 and AMPLITUDE = 512, shared with the filter.
- Sub-module `switch_debounce` (parameter DB_CYCLES) contains the synchroniser and debouncer. It is instantiated once for sw_x, plus once for step_req when the macro is set.

Test Plan:
All scenarios use bench parameters CLK_HZ=100, SAMPLE_HZ=10 (DIV=10), DB_CYCLES=4, SQ_HALF=2.
- Reset then idle with mode 00, sw_x=0 → tick at clocks 10, 20, 30, each one cycle wide; x_val=0; sample_idx = 1, 2, 3.
- Level mode, sw_x raised and held → sw_d rises 6 clocks later; the next tick gives x_val=512. A 3-clock sw_x glitch gives no change.
- Impulse mode, sw_x held high → exactly one tick with x_val=512, then 0 on all later ticks. Dropping and re-raising sw_x gives exactly one more pulse.
- Square mode, sw_x high → x_val sequence over ticks is 512, 512, 0, 0, 512, 512. Dropping sw_x gives 0 on the next tick and clears the phase.
- Reset asserted for 1 clock mid-sequence (impulse FSM in FIRED, sample_idx=7) → next cycle all outputs 0, FSM IDLE. The first tick comes 10 clocks after reset is released.
- SAMPLE_SINGLE_STEP_EN with step_req pulsed high 3 times, each held ≥ 6 clocks → exactly 3 one-cycle ticks; sample_idx = 3; no ticks between presses.
